demap_frame_ctrl: RTL and testbench
===================================

// Module: demap_frame_ctrl
// PURPOSE
//  Frame-level sequencer for the BPSK demap path. Waits for a frame sync, slices
//  incoming I samples to bits and packs them MSB-first into 128-bit words.
//  Runs a fixed word count per frame and hands words to the memory writer over a
//  valid/ready handshake through a 2-entry buffer. Sits between equaliser output
//  and the 128-bit writer; reports overflow and frame completion to control.
// PARAMETERS
//  AR_W             11   width of signed I-sample input
//  WORD_BITS        128  bits per output word
//  WORDS_PER_FRAME  16   words per frame (>=1)
// PORTS
//  CLK          in   1          clock
//  RST          in   1          reset, synchronous, active-low
//  ce           in   1          clock enable for symbol path and FSM
//  sync_det     in   1          start-of-frame pulse (one cycle)
//  sym_valid    in   1          symbol strobe
//  sym_ar       in   AR_W       signed I component of symbol
//  wr_valid     out  1          output word valid
//  wr_ready     in   1          writer accepts word
//  wr_data      out  WORD_BITS  packed word, first symbol in bit WORD_BITS-1
//  wr_last      out  1          wr_data is final word of frame
//  busy         out  1          FSM not IDLE
//  overflow     out  1          sticky: word dropped, buffer full
//  frame_done   out  1          one-cycle pulse, frame fully drained
// BEHAVIOUR
//  Reset (RST=0 at edge): state IDLE, bit/word counters 0, buffer empty, shift
//   reg 0; wr_valid=0, wr_last=0, busy=0, overflow=0, frame_done=0. Reset
//   mid-frame discards all buffered and partial data.
//  Slice: bit = (sym_ar > 0); sym_ar==0 and negatives give 0.
//  ce=0: no symbol accepted, no FSM transition, no counter change; the
//   wr_valid/wr_ready pop side is independent of ce.
//  States:
//   IDLE    : symbols ignored. ce&sync_det -> COLLECT, counters cleared,
//             overflow cleared.
//   COLLECT : ce&sym_valid accepts: shreg = {shreg[WORD_BITS-2:0],bit},
//             bitcnt++. On accepting bit WORD_BITS the completed word (with
//             this bit) is pushed at that edge, bitcnt->0, wordcnt++; pushed
//             entry tagged last when wordcnt==WORDS_PER_FRAME-1; after that
//             push -> FLUSH.
//             ce&sync_det (priority over sym_valid same cycle): partial word
//             discarded, counters cleared, overflow cleared, stay COLLECT;
//             already-buffered words remain and drain normally.
//   FLUSH   : symbols and sync_det ignored; when buffer empty -> IDLE with
//             frame_done=1 for that one cycle.
//  Buffer: 2 entries {data,last}. wr_valid = not empty; wr_data/wr_last from
//   head. Pop on wr_valid&wr_ready. Push and pop in same cycle allowed at any
//   occupancy, incl. full (count unchanged). Push while full with no pop:
//   word dropped, overflow<=1 (sticky until reset or accepted sync), wordcnt
//   still advances so frame length is fixed.
//  Latency: word visible on wr_valid the cycle after the edge accepting its
//   last bit when buffer empty. wr_data/wr_last stable while wr_valid&!wr_ready.
//  Throughput: 1 symbol/cycle sustained; 1 word/cycle drain.
// STRUCTURE
//  Shared defs (comm_demap_defs.vh): WORD_BITS, state encodings
//   ST_IDLE/ST_COLLECT/ST_FLUSH, slice-rule macro, shared by all demappers.
//  Sub-module demap_word_fifo: 2-entry FIFO, params W; ports push/din/full,
//   pop/dout/empty; simultaneous push+pop when full legal. Top holds FSM,
//   counters, shift register, overflow/frame_done logic.
// TESTING
//  1 sync, then 2048 syms alternating +100/-100, wr_ready=1 -> 16 words
//    0xAAAA...AAAA, wr_last only on 16th, frame_done 1 cycle after its pop.
//  2 sym_ar=0 and -1024 throughout one word -> wr_data=0; +1023 -> all ones.
//  3 wr_ready=0 whole frame -> 2 words held, overflow=1 after 3rd push,
//    wr_data unchanged while stalled; FSM stays FLUSH until ready=1.
//  4 sync at bit 70 of word 3 -> partial dropped, next 128 syms form word 0,
//    buffered words 0..2 still delivered, total words = 3+16.
//  5 ce toggled 1/0 each cycle with sym_valid=1 -> only ce=1 syms packed;
//    wr_ready pops proceed during ce=0.
//  6 RST=0 mid-COLLECT with full buffer -> next cycle wr_valid=0, busy=0,
//    overflow=0; symbols ignored until next sync.

Source files
------------

// File: rtl/demap_frame_ctrl_pkg.sv
// Shared definitions for the BPSK demap frame sequencer: FSM encodings,
// default word width and the hard-decision slice rule.
package demap_frame_ctrl_pkg;

  localparam int WORD_BITS_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  // Strictly positive samples decide 1; zero and negatives decide 0.
  function automatic logic slice_bit(input logic sign, input logic nonzero);
    return !sign && nonzero;
  endfunction

endpackage

// File: rtl/demap_frame_ctrl_if.sv
// Word handoff bus from the demap sequencer to the 128-bit memory writer.
interface demap_frame_ctrl_if #(
  parameter int WORD_BITS = 128
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [WORD_BITS-1:0] wr_data;
  logic                 wr_last;

  modport master (output wr_valid, wr_data, wr_last, input wr_ready);
  modport slave  (input wr_valid, wr_data, wr_last, output wr_ready);
endinterface

// File: rtl/demap_frame_ctrl_word_fifo.sv
// Two-entry word buffer; push and pop in the same cycle are legal even when full.
module demap_frame_ctrl_word_fifo #(
  parameter int W = 129
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  logic [1:0][W-1:0] mem;
  logic              wp, rp;
  logic [1:0]        cnt;
  logic              do_push, do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  // When full, a push only lands if the head leaves on the same edge.
  assign do_push = push && ((cnt != 2'd2) || do_pop);
  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign dout    = mem[rp];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      mem <= '0;
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/demap_frame_ctrl.sv
// Frame sequencer for the BPSK demap path: slices I samples, packs them MSB-first
// into words, and hands a fixed number of words per frame to the writer.
module demap_frame_ctrl
  import demap_frame_ctrl_pkg::*;
#(
  parameter int AR_W            = 11,
  parameter int WORD_BITS       = WORD_BITS_DEF,
  parameter int WORDS_PER_FRAME = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ce,
  input  logic                   sync_det,
  input  logic                   sym_valid,
  input  logic signed [AR_W-1:0] sym_ar,
  demap_frame_ctrl_if.master     wr,
  output logic                   busy,
  output logic                   overflow,
  output logic                   frame_done
);
  localparam int BC_W = $clog2(WORD_BITS);
  localparam int WC_W = $clog2(WORDS_PER_FRAME) + 1;
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_BITS - 1);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WORDS_PER_FRAME - 1);

  state_t               state;
  logic [BC_W-1:0]      bitcnt;
  logic [WC_W-1:0]      wordcnt;
  logic [WORD_BITS-1:0] shreg, push_data;
  logic [WORD_BITS:0]   head;
  logic                 sym_bit, take, push, push_last, pop, full, empty;

  assign sym_bit   = slice_bit(sym_ar[AR_W-1], |sym_ar);
  // sync_det wins over a coincident symbol, so that symbol is never packed.
  assign take      = ce && (state == ST_COLLECT) && !sync_det && sym_valid;
  assign push      = take && (bitcnt == BIT_LAST);
  assign push_data = {shreg[WORD_BITS-2:0], sym_bit};
  assign push_last = (wordcnt == WORD_LAST);
  assign pop       = wr.wr_valid && wr.wr_ready;

  assign wr.wr_valid           = !empty;
  assign {wr.wr_last, wr.wr_data} = head;
  assign busy                  = (state != ST_IDLE);

  demap_frame_ctrl_word_fifo #(.W(WORD_BITS + 1)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .din   ({push_last, push_data}),
    .full  (full),
    .pop   (pop),
    .dout  (head),
    .empty (empty)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= ST_IDLE;
      bitcnt     <= '0;
      wordcnt    <= '0;
      shreg      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A dropped word still counts toward the frame so its length stays fixed.
      if (push && full && !pop) overflow <= 1'b1;
      if (ce) begin
        unique case (state)
          ST_IDLE: if (sync_det) begin
            state    <= ST_COLLECT;
            bitcnt   <= '0;
            wordcnt  <= '0;
            overflow <= 1'b0;
          end
          ST_COLLECT: if (sync_det) begin
            bitcnt   <= '0;
            wordcnt  <= '0;
            overflow <= 1'b0;
          end else if (sym_valid) begin
            shreg  <= push_data;
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == BIT_LAST) begin
              bitcnt  <= '0;
              wordcnt <= wordcnt + 1'b1;
              if (push_last) state <= ST_FLUSH;
            end
          end
          ST_FLUSH: if (empty) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demap_frame_ctrl.sv
// Scoreboard bench for demap_frame_ctrl: directed frames push expected words,
// a negedge monitor pops and compares every accepted word.
module tb_demap_frame_ctrl;
  localparam int AR_W = 11;
  localparam int WB   = 128;
  localparam int WPF  = 16;
  localparam logic [WB-1:0] ONES = '1;
  localparam logic [WB-1:0] ZERO = '0;
  localparam logic [WB-1:0] ALT  = {32{4'hA}};

  logic CLK = 1'b0, RST = 1'b0, ce = 1'b0, sync_det = 1'b0, sym_valid = 1'b0;
  logic signed [AR_W-1:0] sym_ar = '0;
  logic busy, overflow, frame_done;

  demap_frame_ctrl_if #(.WORD_BITS(WB)) wr_bus ();

  demap_frame_ctrl #(.AR_W(AR_W), .WORD_BITS(WB), .WORDS_PER_FRAME(WPF)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ce         (ce),
    .sync_det   (sync_det),
    .sym_valid  (sym_valid),
    .sym_ar     (sym_ar),
    .wr         (wr_bus),
    .busy       (busy),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic last; logic [WB-1:0] data; } exp_t;
  exp_t sb[$];
  int nchk = 0, nerr = 0, cyc = 0, npop = 0, last_pop_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every word the writer accepts must match the scoreboard head.
  always @(negedge CLK) begin
    if (RST && wr_bus.wr_valid && wr_bus.wr_ready) begin
      if (sb.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_word: got %h with empty scoreboard", wr_bus.wr_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_data", wr_bus.wr_data, e.data);
        chkb("wr_last", wr_bus.wr_last, e.last);
        npop++;
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int v);
    sym_valid = 1'b1;
    sym_ar    = AR_W'(v);
    tick();
  endtask

  task automatic send_word(input int a, input int b);
    for (int i = 0; i < WB; i++) send((i % 2 == 0) ? a : b);
    sym_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    sync_det = 1'b1;
    tick();
    sync_det = 1'b0;
  endtask

  task automatic expect_word(input logic last, input logic [WB-1:0] data);
    exp_t e;
    e.last = last;
    e.data = data;
    sb.push_back(e);
  endtask

  // frame_done must rise on the edge after the final pop and last one cycle.
  task automatic wait_done(input string name);
    int n = 0;
    while (!frame_done && n < 300) begin
      tick();
      n++;
    end
    nchk++;
    if (!frame_done) begin
      nerr++;
      $display("FAIL %s_done: frame_done not seen within 300 cycles", name);
    end else begin
      chki({name, "_done_lat"}, cyc - last_pop_cyc, 2);
      chkb({name, "_done_busy"}, busy, 1'b0);
      tick();
      chkb({name, "_done_pulse"}, frame_done, 1'b0);
    end
    chki({name, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    int p0;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1);
  end

  initial begin
    int p0;
    ce = 1'b1;
    wr_bus.wr_ready = 1'b1;
    repeat (3) tick();
    chkb("rst_valid", wr_bus.wr_valid, 1'b0);
    chkb("rst_last", wr_bus.wr_last, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_ovf", overflow, 1'b0);
    chkb("rst_done", frame_done, 1'b0);
    RST = 1'b1;
    tick();

    // 1: alternating +/-100 gives 0xAA.. words, last only on the 16th
    pulse_sync();
    chkb("t1_busy", busy, 1'b1);
    for (int k = 0; k < WPF; k++) begin
      expect_word(k == WPF - 1, ALT);
      send_word(100, -100);
      if (k == 0) chkb("t1_latency", wr_bus.wr_valid, 1'b1);
    end
    wait_done("t1");

    // 2: zero and most-negative slice to 0; +1023 and +1 slice to 1
    pulse_sync();
    expect_word(1'b0, ZERO);
    send_word(0, -1024);
    expect_word(1'b0, ONES);
    send_word(1023, 1023);
    for (int k = 2; k < WPF; k++) begin
      expect_word(k == WPF - 1, ONES);
      send_word(1, 1);
    end
    wait_done("t2");

    // 3: writer stalled for the whole frame; only two words survive
    wr_bus.wr_ready = 1'b0;
    pulse_sync();
    expect_word(1'b0, ONES);
    expect_word(1'b0, ZERO);
    for (int k = 0; k < WPF; k++) begin
      send_word((k % 2 == 0) ? 1023 : -1, (k % 2 == 0) ? 1023 : -1);
      if (k == 1) begin
        chkb("t3_ovf_full", overflow, 1'b0);
        chk("t3_head_hold1", wr_bus.wr_data, ONES);
      end
      if (k == 2) chkb("t3_ovf_set", overflow, 1'b1);
    end
    repeat (5) tick();
    chkb("t3_ovf_sticky", overflow, 1'b1);
    chkb("t3_flush_busy", busy, 1'b1);
    chk("t3_head_hold2", wr_bus.wr_data, ONES);
    wr_bus.wr_ready = 1'b1;
    wait_done("t3");
    chkb("t3_ovf_after", overflow, 1'b1);

    // 4: re-sync mid word 3 drops the partial word and restarts the frame
    pulse_sync();
    chkb("t4_ovf_clr", overflow, 1'b0);
    p0 = npop;
    for (int k = 0; k < 3; k++) begin
      expect_word(1'b0, ALT);
      send_word(100, -100);
    end
    for (int i = 0; i < 70; i++) send(100);
    sym_valid = 1'b1;
    sym_ar    = AR_W'(100);
    pulse_sync();
    sym_valid = 1'b0;
    for (int k = 0; k < WPF; k++) begin
      expect_word(k == WPF - 1, ALT);
      send_word(100, -100);
    end
    wait_done("t4");
    chki("t4_word_total", npop - p0, 3 + WPF);

    // 5: ce gating on the symbol path; pops continue while ce=0
    pulse_sync();
    for (int k = 0; k < WPF; k++) expect_word(k == WPF - 1, ONES);
    for (int i = 0; i < 2 * WB * WPF - 1; i++) begin
      ce        = (i % 2 == 0);
      sym_valid = 1'b1;
      sym_ar    = ce ? AR_W'(100) : AR_W'(-100);
      tick();
      if (i == 2 * WB - 2) chkb("t5_word_vis", wr_bus.wr_valid, 1'b1);
      if (i == 2 * WB - 1) chkb("t5_pop_ce0", wr_bus.wr_valid, 1'b0);
    end
    ce = 1'b1;
    sym_valid = 1'b0;
    wait_done("t5");

    // 6: reset mid-frame with a full buffer discards everything
    wr_bus.wr_ready = 1'b0;
    pulse_sync();
    for (int k = 0; k < 3; k++) send_word(1023, 1023);
    for (int i = 0; i < 40; i++) send(100);
    chkb("t6_ovf_pre", overflow, 1'b1);
    chkb("t6_valid_pre", wr_bus.wr_valid, 1'b1);
    RST = 1'b0;
    tick();
    chkb("t6_rst_valid", wr_bus.wr_valid, 1'b0);
    chkb("t6_rst_busy", busy, 1'b0);
    chkb("t6_rst_ovf", overflow, 1'b0);
    RST = 1'b1;
    wr_bus.wr_ready = 1'b1;
    for (int i = 0; i < 200; i++) send(100);
    sym_valid = 1'b0;
    tick();
    chkb("t6_idle_valid", wr_bus.wr_valid, 1'b0);
    chkb("t6_idle_busy", busy, 1'b0);
    chki("sb_final", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
